// File: rtl/alu_mul_seq_if.sv
// Operand request / product response channel of the sequential multiplier.
// The master drives operands and takes products; the slave is the multiplier.
interface alu_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Signed;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Lo;
    logic [WIDTH-1:0] Hi;

    modport master (
        output InValid, A, B, Signed, OutReady,
        input  InReady, OutValid, Lo, Hi
    );

    modport slave (
        input  InValid, A, B, Signed, OutReady,
        output InReady, OutValid, Lo, Hi
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier (signed/unsigned) feeding the ALU bitslice Mul inputs (Lo)
// and the MIPS HI register (Hi). One multiplier bit is retired per RUN cycle.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_mul_seq_if.slave  bus,
    output logic [1:0]    dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid are pure functions of state, never of the peer's signals.

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;

    logic               in_ready;
    logic               out_valid;
    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    assign accept    = (state_q == S_IDLE) && bus.InValid;
    assign last_iter = (count_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)       state_d = S_RUN;
            S_RUN:  if (last_iter)    state_d = S_FIX;
            S_FIX:                    state_d = S_DONE;
            S_DONE: if (bus.OutReady) state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid;
    assign bus.Lo       = lo_q;
    assign bus.Hi       = hi_q;
    assign dbg_state_o  = state_q;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Negating the most-negative value yields 2^(WIDTH-1), which is exact as unsigned.
    assign a_abs = (bus.Signed && bus.A[WIDTH-1]) ? (~bus.A + 1'b1) : bus.A;
    assign b_abs = (bus.Signed && bus.B[WIDTH-1]) ? (~bus.B + 1'b1) : bus.B;

    assign addend   = mplier_q[0] ? mcand_q : '0;
    assign sum      = {1'b0, acc_q} + {1'b0, addend};
    assign prod_raw = {acc_q, mplier_q};
    assign prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;

    always_comb begin
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mcand_d  = a_abs;
                    mplier_d = b_abs;
                    neg_d    = bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = '0;
                end
            end
            S_RUN: begin
                // {acc, mplier} <= {sum, mplier} >> 1
                acc_d    = sum[WIDTH:1];
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                count_d  = count_q + CW'(1);
            end
            S_FIX: begin
                lo_d = prod_fix[WIDTH-1:0];
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: directed corner products, DONE back-pressure,
// mid-RUN reset abort, back-to-back issue and random operands.
module tb_alu_mul_seq;

    localparam int W = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic [2*W-1:0] exp_q[$];

    alu_mul_seq_if #(.WIDTH(W)) bus ();

    alu_mul_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp);
        int n;
        n = 0;
        while (bus.InReady !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("in_ready", bus.InReady, 1);
        bus.A       = a;
        bus.B       = b;
        bus.Signed  = s;
        bus.InValid = 1'b1;
        exp_q.push_back(exp);
        tick();
        acc_cyc     = cyc;
        bus.InValid = 1'b0;
    endtask

    task automatic collect(input int hold);
        int          n;
        logic [63:0] exp;
        n = 0;
        while (bus.OutValid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("out_valid", bus.OutValid, 1);
        check("latency", 64'(cyc - acc_cyc), 64'(W + 1));
        check("sb_size", 64'(exp_q.size()), 64'(1));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        for (int i = 0; i < hold; i++) begin
            bus.InValid = 1'($urandom_range(0, 1));
            bus.A       = $urandom;
            bus.B       = $urandom;
            tick();
            check("hold_ov", bus.OutValid, 1);
            check("hold_ir", bus.InReady, 0);
            check("hold_prod", {bus.Hi, bus.Lo}, exp);
        end
        bus.InValid = 1'b0;
        check("prod", {bus.Hi, bus.Lo}, exp);
        bus.OutReady = 1'b1;
        tick();
        bus.OutReady = 1'b0;
        check("ret_ir", bus.InReady, 1);
        check("ret_ov", bus.OutValid, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        bus.InValid  = 1'b1;
        bus.A        = 32'd3;
        bus.B        = 32'd4;
        bus.Signed   = 1'b0;
        bus.OutReady = 1'b0;
        reset        = 1'b1;
        repeat (3) tick();
        bus.InValid = 1'b0;
        reset       = 1'b0;
        tick();
        check("rst_ir", bus.InReady, 1);
        check("rst_ov", bus.OutValid, 0);
        check("rst_lo", bus.Lo, 0);
        check("rst_hi", bus.Hi, 0);
        check("rst_state", dbg_state, 0);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        collect(0);
        issue(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        collect(0);
        issue(32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB);
        collect(0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        collect(0);
        issue(32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000);
        collect(0);

        // back-pressure in DONE
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1));
        collect(5);

        // reset at RUN iteration 10 aborts the product
        issue(32'hDEAD_BEEF, 32'h0000_0101, 1'b0, 64'h0);
        repeat (10) tick();
        check("mid_run_state", dbg_state, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(exp_q.pop_back());
        check("abort_ir", bus.InReady, 1);
        check("abort_ov", bus.OutValid, 0);
        check("abort_lo", bus.Lo, 0);
        check("abort_hi", bus.Hi, 0);
        issue(32'd6, 32'd7, 1'b1, 64'd42);
        collect(0);

        // back-to-back
        issue(32'd5, 32'd5, 1'b0, 64'd25);
        collect(0);
        issue(32'd0, 32'hFFFF_FFFF, 1'b1, 64'd0);
        collect(0);

        for (int k = 0; k < 10; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (k == 0) ra = 32'h8000_0000;
            if (k == 1) rb = 32'h7FFF_FFFF;
            issue(ra, rb, rs, model(ra, rb, rs));
            collect(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
